ddr_rd_arbiter: RTL and testbench
=================================

DDR_RD_ARBITER -- requirements
Module: ddr_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of read requesters (2..4).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, AXI read data width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, maximum issued but uncompleted bursts (power of 2).
REQ-005 SHALL have parameter BURST_LEN, default 64, beats per burst; m_axi_arlen = BURST_LEN-1.
REQ-006 SHALL have port axi_aclk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port axi_aresetn, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port req_araddr, input, NUM_REQ*ADDR_WIDTH, per-requester burst address, requester i at slice i.
REQ-009 SHALL have port req_arvalid / req_arready, input / output, NUM_REQ each, per-requester address handshake.
REQ-010 SHALL have port req_rdata, output, DATA_WIDTH, shared return data, broadcast to all requesters.
REQ-011 SHALL have port req_rvalid / req_rlast, output, NUM_REQ each, per-requester beat valid and last.
REQ-012 SHALL have port req_rready, input, NUM_REQ, per-requester beat ready.
REQ-013 SHALL have ports m_axi_araddr (ADDR_WIDTH), m_axi_arvalid, m_axi_arlen (8), m_axi_arsize (3), m_axi_arburst (2), all outputs; m_axi_arready input.
REQ-014 SHALL have ports m_axi_rdata (DATA_WIDTH), m_axi_rvalid, m_axi_rlast, all inputs; m_axi_rready output.

Function
REQ-015 SHALL drive m_axi_arlen=BURST_LEN-1, m_axi_arsize=log2(DATA_WIDTH/8), m_axi_arburst=2'b01 (INCR) as constants.
REQ-016 SHALL implement AR FSM with states IDLE and ISSUE.
REQ-017 In IDLE, when any req_arvalid is high and the tag FIFO is not full, SHALL select a winner by round-robin starting at index last_grant+1, register its address and index, and go to ISSUE the next cycle.
REQ-018 In ISSUE, SHALL hold m_axi_arvalid=1 and m_axi_araddr stable until m_axi_arready; on handshake, pulse req_arready[winner] for that same cycle, push winner index into the tag FIFO, update last_grant, return to IDLE.
REQ-019 SHALL assert req_arready only in the AR handshake cycle; requesters must hold req_araddr/req_arvalid until then.
REQ-020 SHALL not enter ISSUE while the tag FIFO holds MAX_OUTSTANDING entries; a pop in the same cycle does not unblock it (full evaluated on registered count).
REQ-021 Tag FIFO SHALL be in-order, depth MAX_OUTSTANDING, with wrap-around pointers and simultaneous push and pop leaving the count unchanged.
REQ-022 R path SHALL be combinational pass-through: when FIFO non-empty with head h, req_rvalid[h]=m_axi_rvalid, req_rlast[h]=m_axi_rlast, m_axi_rready=req_rready[h]; other requester outputs 0.
REQ-023 When FIFO empty, SHALL drive m_axi_rready=0 and all req_rvalid=0.
REQ-024 SHALL pop the FIFO on m_axi_rvalid & m_axi_rready & m_axi_rlast.
REQ-025 Minimum AR latency: req_arvalid sampled in cycle N, m_axi_arvalid high in cycle N+1.

Reset
REQ-026 On axi_aresetn low, asynchronously: FSM=IDLE, m_axi_arvalid=0, m_axi_araddr=0, req_arready=0, FIFO pointers and count=0, last_grant=NUM_REQ-1 (so requester 0 wins first).
REQ-027 Reset mid-burst SHALL discard all outstanding tags; outputs return to reset values immediately.

Configuration
REQ-028 With macro DDR_RD_ARB_PERF_EN defined, SHALL add output perf_bursts (NUM_REQ*16), per-requester count of completed bursts (incremented on pop for head index), wrapping at 2^16, cleared by reset.
REQ-029 Without DDR_RD_ARB_PERF_EN, port perf_bursts and its counters SHALL not exist.

Verification
REQ-030 Single requester: req 0 arvalid addr 0x1000, arready tied 1 -> m_axi_araddr=0x1000 one cycle later, arlen=63, req_arready[0] pulses once, 64 beats routed to req 0 only.
REQ-031 Contention: reqs 0 and 1 valid continuously -> bursts issued alternately 0,1,0,1; return data routed in the same order.
REQ-032 Backpressure: hold m_axi_arready=0 for 10 cycles -> m_axi_arvalid high, araddr stable throughout, no req_arready pulse.
REQ-033 Outstanding limit: 4 bursts issued with no R data -> 5th request stalled in IDLE until first rlast handshake, then issued the following cycle.
REQ-034 Reset asserted mid-burst at beat 20 -> all outputs at reset values asynchronously; after release, new request to addr 0x2000 issues normally.
REQ-035 With DDR_RD_ARB_PERF_EN: 3 bursts for req 1 completed -> perf_bursts slice 1 = 3, slice 0 = 0.

Source files
------------

// File: rtl/ddr_rd_arbiter.sv
// Round-robin read arbiter: NUM_REQ requesters share one AXI read master, with
// in-order tag FIFO routing of R beats. Define DDR_RD_ARB_PERF_EN for burst counters.
module ddr_rd_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int BURST_LEN       = 64
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
  input  logic [NUM_REQ-1:0]            req_arvalid,
  output logic [NUM_REQ-1:0]            req_arready,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]            req_rvalid,
  output logic [NUM_REQ-1:0]            req_rlast,
  input  logic [NUM_REQ-1:0]            req_rready,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic                          m_axi_arvalid,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  input  logic                          m_axi_arready,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic                          m_axi_rvalid,
  input  logic                          m_axi_rlast,
  output logic                          m_axi_rready
`ifdef DDR_RD_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]         perf_bursts
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [7:0]       ARLEN    = 8'(BURST_LEN - 1);
  localparam logic [2:0]       ARSIZE   = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [1:0]       ARBURST  = 2'b01;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_araddr;
  logic [ADDR_WIDTH-1:0]   w_araddr_nxt;
  logic [IDX_W-1:0]        r_winner;
  logic [IDX_W-1:0]        w_winner_nxt;
  logic [IDX_W-1:0]        r_last_grant;
  logic [IDX_W-1:0]        w_last_grant_nxt;
  logic [IDX_W-1:0]        w_rr_cand;
  logic [IDX_W-1:0]        w_rr_idx;
  logic                    w_rr_found;

  logic [IDX_W-1:0]        r_tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic [IDX_W-1:0]        w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign m_axi_arlen   = ARLEN;
  assign m_axi_arsize  = ARSIZE;
  assign m_axi_arburst = ARBURST;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arvalid = (r_state == ST_ISSUE);

  // Full is taken from the registered count, so a pop in the same cycle never unblocks IDLE.
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == {CNT_W{1'b0}});
  assign w_head  = r_tag_mem[r_rd_ptr];
  assign w_pop   = m_axi_rvalid & m_axi_rready & m_axi_rlast;

  // Round-robin pick; scanning from the far end lets the nearest candidate after last_grant win.
  always_comb begin
    w_rr_idx   = {IDX_W{1'b0}};
    w_rr_cand  = {IDX_W{1'b0}};
    w_rr_found = |req_arvalid;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_rr_cand = IDX_W'((int'(r_last_grant) + 1 + k) % NUM_REQ);
      w_rr_idx  = req_arvalid[w_rr_cand] ? w_rr_cand : w_rr_idx;
    end
  end

  // AR FSM next-state and handshake outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_araddr_nxt     = r_araddr;
    w_winner_nxt     = r_winner;
    w_last_grant_nxt = r_last_grant;
    w_push           = 1'b0;
    req_arready      = {NUM_REQ{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (w_rr_found && !w_full) begin
          w_state_nxt  = ST_ISSUE;
          w_winner_nxt = w_rr_idx;
          w_araddr_nxt = req_araddr[int'(w_rr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (m_axi_arready) begin
          w_push                = 1'b1;
          req_arready[r_winner] = 1'b1;
          w_last_grant_nxt      = r_winner;
          w_state_nxt           = ST_IDLE;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // AR FSM state and captured request.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state      <= ST_IDLE;
      r_araddr     <= {ADDR_WIDTH{1'b0}};
      r_winner     <= {IDX_W{1'b0}};
      r_last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_araddr     <= w_araddr_nxt;
      r_winner     <= w_winner_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // In-order tag FIFO: one entry per issued burst, retired on the burst's last beat.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_tag_mem[i] <= {IDX_W{1'b0}};
      end
    end else begin
      if (w_push) begin
        r_tag_mem[r_wr_ptr] <= r_winner;
        r_wr_ptr            <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign req_rdata = m_axi_rdata;

  // R path: steer valid/last to the head requester and take ready from it.
  always_comb begin
    req_rvalid   = {NUM_REQ{1'b0}};
    req_rlast    = {NUM_REQ{1'b0}};
    m_axi_rready = 1'b0;
    if (!w_empty) begin
      req_rvalid[w_head] = m_axi_rvalid;
      req_rlast[w_head]  = m_axi_rlast;
      m_axi_rready       = req_rready[w_head];
    end else begin
      m_axi_rready = 1'b0;
    end
  end

`ifdef DDR_RD_ARB_PERF_EN
  logic [15:0] r_perf_cnt [NUM_REQ];

  // Completed-burst counters, wrapping at 2^16.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_perf_cnt[i] <= 16'd0;
      end
    end else if (w_pop) begin
      r_perf_cnt[w_head] <= r_perf_cnt[w_head] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    assign perf_bursts[g*16 +: 16] = r_perf_cnt[g];
  end
`endif

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed self-checking bench for ddr_rd_arbiter (3 requesters): vector table
// for round-robin/routing, plus hand-written multi-cycle sequences.
module tb_ddr_rd_arbiter;
  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int BL = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR*AW-1:0] req_araddr;
  logic [NR-1:0]    req_arvalid;
  logic [NR-1:0]    req_arready;
  logic [DW-1:0]    req_rdata;
  logic [NR-1:0]    req_rvalid;
  logic [NR-1:0]    req_rlast;
  logic [NR-1:0]    req_rready;
  logic [AW-1:0]    m_axi_araddr;
  logic             m_axi_arvalid;
  logic [7:0]       m_axi_arlen;
  logic [2:0]       m_axi_arsize;
  logic [1:0]       m_axi_arburst;
  logic             m_axi_arready;
  logic [DW-1:0]    m_axi_rdata;
  logic             m_axi_rvalid;
  logic             m_axi_rlast;
  logic             m_axi_rready;
`ifdef DDR_RD_ARB_PERF_EN
  logic [NR*16-1:0] perf_bursts;
`endif

  ddr_rd_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MAX_OUTSTANDING(MO), .BURST_LEN(BL)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .req_araddr(req_araddr), .req_arvalid(req_arvalid), .req_arready(req_arready),
    .req_rdata(req_rdata), .req_rvalid(req_rvalid), .req_rlast(req_rlast),
    .req_rready(req_rready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast),
    .m_axi_rready(m_axi_rready)
`ifdef DDR_RD_ARB_PERF_EN
    , .perf_bursts(perf_bursts)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [NR-1:0] mask;
    int            exp;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_araddr[i*AW +: AW] = a;
  endtask

  function automatic logic [NR-1:0] onehot(input int i);
    onehot = NR'(1) << i;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, m_axi_arvalid, 0);
    check({tag, "_araddr"}, m_axi_araddr, 0);
    check({tag, "_arready"}, req_arready, 0);
    check({tag, "_rvalid"}, req_rvalid, 0);
    check({tag, "_rready"}, m_axi_rready, 0);
  endtask

  task automatic one_beat(input string name, input int who, input logic [DW-1:0] d);
    m_axi_rdata  = d;
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = 1'b1;
    #1;
    check({name, "_rvalid"}, req_rvalid, onehot(who));
    check({name, "_rlast"}, req_rlast, onehot(who));
    step();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ea;
    int            pulses;
    int            bad;
    int            n;
    int            order [4];

    vecs[0] = '{3'b011, 0};
    vecs[1] = '{3'b011, 1};
    vecs[2] = '{3'b111, 2};
    vecs[3] = '{3'b110, 1};
    vecs[4] = '{3'b001, 0};
    vecs[5] = '{3'b101, 2};
    vecs[6] = '{3'b100, 2};
    vecs[7] = '{3'b011, 0};

    req_araddr    = '0;
    req_arvalid   = '0;
    req_rready    = '1;
    m_axi_arready = 1'b1;
    m_axi_rdata   = '0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;

    #1;
    check_reset_outputs("rst");
    check("arlen", m_axi_arlen, 63);
    check("arsize", m_axi_arsize, 2);
    check("arburst", m_axi_arburst, 1);
    step();
    step();
    rst_n = 1'b1;

    // Round-robin and routing vectors, one single-beat burst each
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < NR; i++) set_addr(i, 32'((i + 1) * 32'h10000 + v * 16));
      ea = 32'((vecs[v].exp + 1) * 32'h10000 + v * 16);
      req_arvalid = vecs[v].mask;
      step();
      check("arb_arvalid", m_axi_arvalid, 1);
      check("arb_araddr", m_axi_araddr, ea);
      check("arb_arready", req_arready, onehot(vecs[v].exp));
      step();
      req_arvalid = '0;
      check("arb_arready_drop", req_arready, 0);
      m_axi_rdata  = 32'hD000_0000 + 32'(v);
      m_axi_rvalid = 1'b1;
      m_axi_rlast  = 1'b1;
      #1;
      check("arb_rvalid", req_rvalid, onehot(vecs[v].exp));
      check("arb_rlast", req_rlast, onehot(vecs[v].exp));
      check("arb_rdata", req_rdata, 32'hD000_0000 + 32'(v));
      check("arb_mrready", m_axi_rready, 1);
      step();
      m_axi_rlast = 1'b0;
      #1;
      check("arb_empty_rvalid", req_rvalid, 0);
      check("arb_empty_rready", m_axi_rready, 0);
      m_axi_rvalid = 1'b0;
    end

    // Single requester, full 64-beat burst
    set_addr(0, 32'h1000);
    req_arvalid = 3'b001;
    step();
    check("single_arvalid", m_axi_arvalid, 1);
    check("single_araddr", m_axi_araddr, 32'h1000);
    pulses = (req_arready == 3'b001) ? 1 : 0;
    step();
    req_arvalid = '0;
    for (int c = 0; c < 4; c++) begin
      if (req_arready != 3'b000) pulses++;
      step();
    end
    check("single_arready_pulses", pulses, 1);
    m_axi_rvalid = 1'b1;
    req_rready   = 3'b110;
    #1;
    check("single_rready_follow", m_axi_rready, 0);
    req_rready = 3'b111;
    bad = 0;
    for (int b = 0; b < BL; b++) begin
      m_axi_rdata = 32'(b);
      m_axi_rlast = (b == BL - 1);
      #1;
      if (req_rvalid !== 3'b001 || req_rlast !== ((b == BL - 1) ? 3'b001 : 3'b000) ||
          req_rdata !== 32'(b) || m_axi_rready !== 1'b1) bad++;
      step();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    check("single_beats_bad", bad, 0);

    // Backpressure on AR
    m_axi_arready = 1'b0;
    set_addr(1, 32'h3000);
    req_arvalid = 3'b010;
    step();
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h3000 || req_arready !== 3'b000) bad++;
      step();
    end
    check("bp_hold_bad", bad, 0);
    m_axi_arready = 1'b1;
    #1;
    check("bp_arready", req_arready, 3'b010);
    step();
    req_arvalid = '0;
    one_beat("bp_ret", 1, 32'hBB);

    // Outstanding limit
    set_addr(0, 32'h4000);
    req_arvalid = 3'b001;
    pulses = 0;
    for (int c = 0; c < 40 && pulses < 4; c++) begin
      step();
      if (req_arready[0]) pulses++;
    end
    check("os_issued", pulses, 4);
    step();
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      if (m_axi_arvalid !== 1'b0 || req_arready !== 3'b000) bad++;
      step();
    end
    check("os_stall_bad", bad, 0);
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = 1'b1;
    #1;
    check("os_first_rvalid", req_rvalid, 3'b001);
    step();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    check("os_no_issue_on_pop", m_axi_arvalid, 0);
    step();
    check("os_issue_after_pop", m_axi_arvalid, 1);
    check("os_arready_after_pop", req_arready, 3'b001);
    step();
    req_arvalid = '0;
    for (int k = 0; k < 4; k++) one_beat("os_drain", 0, 32'(k));
    m_axi_rvalid = 1'b1;
    #1;
    check("os_drained", m_axi_rready, 0);
    m_axi_rvalid = 1'b0;

    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst2");
    step();
    rst_n = 1'b1;

    // Contention between requesters 0 and 1
    set_addr(0, 32'h5000);
    set_addr(1, 32'h6000);
    req_arvalid = 3'b011;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      step();
      if (req_arready != 3'b000) begin
        order[n] = (req_arready == 3'b001) ? 0 : (req_arready == 3'b010) ? 1 : 9;
        n++;
      end
    end
    step();
    req_arvalid = '0;
    check("cont_count", n, 4);
    for (int k = 0; k < 4; k++) check("cont_order", order[k], k % 2);
    for (int k = 0; k < 4; k++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rlast  = 1'b0;
      #1;
      check("cont_beat0", req_rvalid, onehot(k % 2));
      step();
      one_beat("cont_beat1", k % 2, 32'h100 + 32'(k));
    end

    // Reset in the middle of a burst
    set_addr(0, 32'h7000);
    req_arvalid = 3'b001;
    step();
    step();
    req_arvalid = '0;
    m_axi_rvalid = 1'b1;
    for (int b = 0; b < 20; b++) step();
    check("mid_rvalid_before", req_rvalid, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    set_addr(0, 32'h2000);
    step();
    rst_n = 1'b1;
    #1;
    check("mid_tags_dropped_rvalid", req_rvalid, 0);
    check("mid_tags_dropped_rready", m_axi_rready, 0);
    m_axi_rvalid = 1'b0;
    req_arvalid  = 3'b001;
    step();
    check("mid_new_araddr", m_axi_araddr, 32'h2000);
    check("mid_new_arready", req_arready, 3'b001);
    step();
    req_arvalid = '0;
    one_beat("mid_new_ret", 0, 32'h2000);

`ifdef DDR_RD_ARB_PERF_EN
    rst_n = 1'b0;
    #1;
    check("perf_reset", perf_bursts, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_addr(1, 32'h8000 + 32'(k) * 32'h100);
      req_arvalid = 3'b010;
      step();
      step();
      req_arvalid = '0;
      one_beat("perf_ret", 1, 32'(k));
    end
    check("perf_slice0", perf_bursts[15:0], 0);
    check("perf_slice1", perf_bursts[31:16], 3);
    check("perf_slice2", perf_bursts[47:32], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
